// File: rtl/cc_game_pkg.sv
// ---------------------------------------------------------------------------
// cc_game_pkg
// Shared definitions for the game status tracker:
//   - game_state_t : FSM state encoding (PLAY, NESTED, DEAD, WON)
//   - DEF_*        : default playfield geometry and row indices
//   - LIVES_W      : width of the lives counter
//   - lives_sat_dec: decrement of the lives counter that stops at zero
// ---------------------------------------------------------------------------
package cc_game_pkg;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    NESTED = 2'd1,
    DEAD   = 2'd2,
    WON    = 2'd3
  } game_state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_ROWS        = 8;
  localparam int DEF_START_ROW   = 0;
  localparam int DEF_POWERUP_ROW = 2;

  localparam int LIVES_W = 4;

  // Lives never wrap below zero.
  function automatic logic [LIVES_W-1:0] lives_sat_dec(input logic [LIVES_W-1:0] lives);
    if (lives == 4'd0) begin
      return 4'd0;
    end else begin
      return lives - 4'd1;
    end
  endfunction

endpackage

// File: rtl/cc_shield_timer.sv
// ---------------------------------------------------------------------------
// cc_shield_timer
// Shield countdown. A load request (re)starts the counter at SHIELD_CYCLES;
// the counter then counts down once per clock and the shield is active while
// it is nonzero. Only compiled when CC_GAME_STATUS_TRACKER_SHIELD_EN is
// defined, so the default build carries no shield hardware at all.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset (clears the counter)
//   load_i   - power-up pickup, reloads the counter
//   shield_o - shield active
// ---------------------------------------------------------------------------
`ifdef CC_GAME_STATUS_TRACKER_SHIELD_EN
module cc_shield_timer #(
  parameter int SHIELD_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic shield_o
);

  localparam int CNT_W = (SHIELD_CYCLES < 1) ? 1 : $clog2(SHIELD_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a reload wins over the running countdown.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(SHIELD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shield_o = (cnt_q != '0);

endmodule
`endif

// File: rtl/cc_game_status_tracker.sv
// ---------------------------------------------------------------------------
// cc_game_status_tracker
// Tracks the status of a frogger-style game: deaths on hazard rows, nesting
// on the goal row, level wins, game over and power-up pickups. All status
// outputs are registered, so they follow the inputs with one cycle latency.
// Optional feature: define CC_GAME_STATUS_TRACKER_SHIELD_EN to add a shield
// that ignores hazard hits for SHIELD_CYCLES cycles after a power-up.
// Ports:
//   CC_GAME_STATUS_TRACKER_CLOCK_50      - clock
//   CC_GAME_STATUS_TRACKER_RESET_InHigh  - synchronous active-high reset
//   CC_GAME_STATUS_TRACKER_BACK_In       - background rows, row r at [r*WIDTH +: WIDTH]
//   CC_GAME_STATUS_TRACKER_POINT_In      - player rows, same packing
//   CC_GAME_STATUS_TRACKER_STATE_Out     - FSM state
//   CC_GAME_STATUS_TRACKER_LIVES_Out     - remaining lives
//   CC_GAME_STATUS_TRACKER_LEVEL_Out     - completed level count
//   CC_GAME_STATUS_TRACKER_NESTMASK_Out  - filled nests
//   CC_GAME_STATUS_TRACKER_LOSE_Out      - pulse on death
//   CC_GAME_STATUS_TRACKER_NEST_Out      - pulse on nesting
//   CC_GAME_STATUS_TRACKER_WINL_Out      - level won (held)
//   CC_GAME_STATUS_TRACKER_GAMEOVER_Out  - game over (held)
//   CC_GAME_STATUS_TRACKER_POWERUP_Out   - pulse on power-up pickup
//   CC_GAME_STATUS_TRACKER_SHIELD_Out    - shield active
// ---------------------------------------------------------------------------
module cc_game_status_tracker
  import cc_game_pkg::*;
#(
  parameter int              WIDTH         = DEF_WIDTH,
  parameter int              ROWS          = DEF_ROWS,
  parameter int              GOAL_ROW      = ROWS - 1,
  parameter int              START_ROW     = DEF_START_ROW,
  parameter int              POWERUP_ROW   = DEF_POWERUP_ROW,
  parameter logic [ROWS-1:0] HAZARD_MASK   = 8'b10101010,
  parameter int              LIVES_INIT    = 3,
  parameter int              SHIELD_CYCLES = 255,
  parameter int              LEVEL_W       = 4
) (
  input  logic                  CC_GAME_STATUS_TRACKER_CLOCK_50,
  input  logic                  CC_GAME_STATUS_TRACKER_RESET_InHigh,
  input  logic [ROWS*WIDTH-1:0] CC_GAME_STATUS_TRACKER_BACK_In,
  input  logic [ROWS*WIDTH-1:0] CC_GAME_STATUS_TRACKER_POINT_In,
  output logic [1:0]            CC_GAME_STATUS_TRACKER_STATE_Out,
  output logic [3:0]            CC_GAME_STATUS_TRACKER_LIVES_Out,
  output logic [LEVEL_W-1:0]    CC_GAME_STATUS_TRACKER_LEVEL_Out,
  output logic [WIDTH-1:0]      CC_GAME_STATUS_TRACKER_NESTMASK_Out,
  output logic                  CC_GAME_STATUS_TRACKER_LOSE_Out,
  output logic                  CC_GAME_STATUS_TRACKER_NEST_Out,
  output logic                  CC_GAME_STATUS_TRACKER_WINL_Out,
  output logic                  CC_GAME_STATUS_TRACKER_GAMEOVER_Out,
  output logic                  CC_GAME_STATUS_TRACKER_POWERUP_Out,
  output logic                  CC_GAME_STATUS_TRACKER_SHIELD_Out
);

  logic clk_s;
  logic rst_s;
  assign clk_s = CC_GAME_STATUS_TRACKER_CLOCK_50;
  assign rst_s = CC_GAME_STATUS_TRACKER_RESET_InHigh;

  // Registered state
  game_state_t          state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [WIDTH-1:0]     nestmask_q, nestmask_d;
  logic                 lose_q, lose_d;
  logic                 nest_q, nest_d;
  logic                 winl_q, winl_d;
  logic                 gameover_q, gameover_d;
  logic                 powerup_q, powerup_d;
  logic                 pu_prev_q;

  // Decoded playfield conditions
  logic [WIDTH-1:0]     point_goal_s;
  logic [WIDTH-1:0]     nest_new_s;
  logic                 hit_s;
  logic                 re_nest_s;
  logic                 at_goal_s;
  logic                 at_start_s;
  logic                 pu_overlap_s;
  logic                 shield_s;
  logic                 death_s;

  assign point_goal_s = CC_GAME_STATUS_TRACKER_POINT_In[GOAL_ROW*WIDTH +: WIDTH];
  assign re_nest_s    = |(point_goal_s & nestmask_q);
  assign at_goal_s    = |point_goal_s;
  assign at_start_s   = |CC_GAME_STATUS_TRACKER_POINT_In[START_ROW*WIDTH +: WIDTH];
  assign pu_overlap_s = |(CC_GAME_STATUS_TRACKER_BACK_In[POWERUP_ROW*WIDTH +: WIDTH] &
                          CC_GAME_STATUS_TRACKER_POINT_In[POWERUP_ROW*WIDTH +: WIDTH]);
  assign nest_new_s   = nestmask_q | point_goal_s;

  // Hazard collision: any hazard row (the nest row never counts) where the
  // player overlaps the background.
  always_comb begin
    hit_s = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (HAZARD_MASK[r] && (r != GOAL_ROW)) begin
        hit_s = hit_s | (|(CC_GAME_STATUS_TRACKER_BACK_In[r*WIDTH +: WIDTH] &
                           CC_GAME_STATUS_TRACKER_POINT_In[r*WIDTH +: WIDTH]));
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Power-up fires on the rising edge of the overlap, but never while dead.
  assign powerup_d = pu_overlap_s & ~pu_prev_q & (state_q != DEAD);

`ifdef CC_GAME_STATUS_TRACKER_SHIELD_EN
  // Loaded from the same-edge pickup so SHIELD rises together with POWERUP.
  cc_shield_timer #(
    .SHIELD_CYCLES(SHIELD_CYCLES)
  ) u_shield (
    .clk_i    (clk_s),
    .rst_i    (rst_s),
    .load_i   (powerup_d),
    .shield_o (shield_s)
  );
`else
  logic unused_shield_cfg_s;
  assign shield_s            = 1'b0;
  assign unused_shield_cfg_s = (SHIELD_CYCLES == 0);
`endif

  // Re-entering a filled nest is fatal even with the shield up.
  assign death_s = (hit_s & ~shield_s) | re_nest_s;

  // Only some rows feed the decoders; the rest of the buses are don't-care.
  logic unused_rows_s;
  assign unused_rows_s = ^{CC_GAME_STATUS_TRACKER_BACK_In, CC_GAME_STATUS_TRACKER_POINT_In};

  // State register together with all status registers.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q    <= PLAY;
      lives_q    <= LIVES_W'(LIVES_INIT);
      level_q    <= '0;
      nestmask_q <= '0;
      lose_q     <= 1'b0;
      nest_q     <= 1'b0;
      winl_q     <= 1'b0;
      gameover_q <= 1'b0;
      powerup_q  <= 1'b0;
      pu_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      nestmask_q <= nestmask_d;
      lose_q     <= lose_d;
      nest_q     <= nest_d;
      winl_q     <= winl_d;
      gameover_q <= gameover_d;
      powerup_q  <= powerup_d;
      pu_prev_q  <= pu_overlap_s;
    end
  end

  // Next-state and status update logic.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    nestmask_d = nestmask_q;
    winl_d     = winl_q;
    gameover_d = gameover_q;
    lose_d     = 1'b0;
    nest_d     = 1'b0;
    case (state_q)
      PLAY: begin
        if (death_s) begin
          // Death outranks a nesting in the same cycle.
          state_d = DEAD;
          lose_d  = 1'b1;
          lives_d = lives_sat_dec(lives_q);
          if (lives_q <= 4'd1) begin
            gameover_d = 1'b1;
          end else begin
            gameover_d = gameover_q;
          end
        end else if (at_goal_s) begin
          nestmask_d = nest_new_s;
          nest_d     = 1'b1;
          if (&nest_new_s) begin
            state_d = WON;
            winl_d  = 1'b1;
            level_d = level_q + LEVEL_W'(1);
          end else begin
            state_d = NESTED;
          end
        end else begin
          state_d = PLAY;
        end
      end
      NESTED: begin
        if (at_start_s) begin
          state_d = PLAY;
        end else begin
          state_d = NESTED;
        end
      end
      DEAD: begin
        if (lives_q == 4'd0) begin
          // Out of lives: locked here until reset.
          gameover_d = 1'b1;
          state_d    = DEAD;
        end else if (at_start_s) begin
          state_d = PLAY;
        end else begin
          state_d = DEAD;
        end
      end
      WON: begin
        if (at_start_s) begin
          nestmask_d = '0;
          winl_d     = 1'b0;
          state_d    = PLAY;
        end else begin
          state_d = WON;
        end
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // Output drive straight from the registers.
  always_comb begin
    CC_GAME_STATUS_TRACKER_STATE_Out    = state_q;
    CC_GAME_STATUS_TRACKER_LIVES_Out    = lives_q;
    CC_GAME_STATUS_TRACKER_LEVEL_Out    = level_q;
    CC_GAME_STATUS_TRACKER_NESTMASK_Out = nestmask_q;
    CC_GAME_STATUS_TRACKER_LOSE_Out     = lose_q;
    CC_GAME_STATUS_TRACKER_NEST_Out     = nest_q;
    CC_GAME_STATUS_TRACKER_WINL_Out     = winl_q;
    CC_GAME_STATUS_TRACKER_GAMEOVER_Out = gameover_q;
    CC_GAME_STATUS_TRACKER_POWERUP_Out  = powerup_q;
    CC_GAME_STATUS_TRACKER_SHIELD_Out   = shield_s;
  end

endmodule

// File: tb/tb_cc_game_status_tracker.sv
// Directed-vector bench for cc_game_status_tracker (default geometry,
// SHIELD_CYCLES overridden to 4). Inputs change #1 after a rising edge and
// outputs are sampled at that same point, so every check sees the result of
// the edge just taken.
module tb_cc_game_status_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] back = 64'd0;
  logic [63:0] point = 64'd0;
  logic [1:0]  state_o;
  logic [3:0]  lives_o;
  logic [3:0]  level_o;
  logic [7:0]  mask_o;
  logic        lose_o, nest_o, winl_o, gov_o, pu_o, sh_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  cc_game_status_tracker #(.SHIELD_CYCLES(4)) dut (
    .CC_GAME_STATUS_TRACKER_CLOCK_50     (clk),
    .CC_GAME_STATUS_TRACKER_RESET_InHigh (rst),
    .CC_GAME_STATUS_TRACKER_BACK_In      (back),
    .CC_GAME_STATUS_TRACKER_POINT_In     (point),
    .CC_GAME_STATUS_TRACKER_STATE_Out    (state_o),
    .CC_GAME_STATUS_TRACKER_LIVES_Out    (lives_o),
    .CC_GAME_STATUS_TRACKER_LEVEL_Out    (level_o),
    .CC_GAME_STATUS_TRACKER_NESTMASK_Out (mask_o),
    .CC_GAME_STATUS_TRACKER_LOSE_Out     (lose_o),
    .CC_GAME_STATUS_TRACKER_NEST_Out     (nest_o),
    .CC_GAME_STATUS_TRACKER_WINL_Out     (winl_o),
    .CC_GAME_STATUS_TRACKER_GAMEOVER_Out (gov_o),
    .CC_GAME_STATUS_TRACKER_POWERUP_Out  (pu_o),
    .CC_GAME_STATUS_TRACKER_SHIELD_Out   (sh_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Player occupies only the given row.
  task automatic place(input int row, input logic [7:0] val);
    point = 64'd0;
    point[row*8 +: 8] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    back = 64'd0;
    point = 64'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", state_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd3) $display("FAIL reset_lives got %0d want 3", lives_o); else pass_cnt++;
    total_cnt++; if (level_o !== 4'd0) $display("FAIL reset_level got %0d want 0", level_o); else pass_cnt++;
    total_cnt++; if (mask_o !== 8'h00) $display("FAIL reset_mask got %h want 00", mask_o); else pass_cnt++;
    total_cnt++; if ({lose_o, nest_o, winl_o, gov_o, pu_o, sh_o} !== 6'b000000)
      $display("FAIL reset_flags got %b want 000000", {lose_o, nest_o, winl_o, gov_o, pu_o, sh_o}); else pass_cnt++;
  endtask

  task automatic test_death();
    back = 64'd0;
    back[1*8 +: 8] = 8'h10;
    place(1, 8'h10);
    tick();
    total_cnt++; if (state_o !== 2'd2) $display("FAIL death_state got %0d want 2", state_o); else pass_cnt++;
    total_cnt++; if (lose_o !== 1'b1) $display("FAIL death_lose got %b want 1", lose_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd2) $display("FAIL death_lives got %0d want 2", lives_o); else pass_cnt++;
    tick();
    total_cnt++; if (lose_o !== 1'b0) $display("FAIL death_lose_once got %b want 0", lose_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd2) $display("FAIL death_lives_hold got %0d want 2", lives_o); else pass_cnt++;
    place(0, 8'h10);
    tick();
    total_cnt++; if (state_o !== 2'd0) $display("FAIL respawn_state got %0d want 0", state_o); else pass_cnt++;
  endtask

  task automatic test_win();
    int pulses = 0;
    logic [7:0] v;
    back = 64'd0;
    for (int i = 0; i < 8; i++) begin
      v = 8'h01 << i;
      place(7, v);
      tick();
      if (nest_o === 1'b1) pulses++;
      total_cnt++; if (state_o !== ((i == 7) ? 2'd3 : 2'd1))
        $display("FAIL win_nest_state_%0d got %0d want %0d", i, state_o, (i == 7) ? 3 : 1); else pass_cnt++;
      if (i == 7) begin
        total_cnt++; if (mask_o !== 8'hFF) $display("FAIL win_mask got %h want FF", mask_o); else pass_cnt++;
        total_cnt++; if (winl_o !== 1'b1) $display("FAIL win_winl got %b want 1", winl_o); else pass_cnt++;
        total_cnt++; if (level_o !== 4'd1) $display("FAIL win_level got %0d want 1", level_o); else pass_cnt++;
      end
      place(0, 8'h01);
      tick();
      if (nest_o === 1'b1) pulses++;
    end
    total_cnt++; if (pulses != 8) $display("FAIL win_nest_pulses got %0d want 8", pulses); else pass_cnt++;
    total_cnt++; if (mask_o !== 8'h00) $display("FAIL win_clear_mask got %h want 00", mask_o); else pass_cnt++;
    total_cnt++; if (winl_o !== 1'b0) $display("FAIL win_clear_winl got %b want 0", winl_o); else pass_cnt++;
    total_cnt++; if (state_o !== 2'd0) $display("FAIL win_clear_state got %0d want 0", state_o); else pass_cnt++;
  endtask

  task automatic test_renest();
    place(7, 8'h01);
    tick();
    place(0, 8'h01);
    tick();
    total_cnt++; if (mask_o !== 8'h01) $display("FAIL renest_setup_mask got %h want 01", mask_o); else pass_cnt++;
    place(7, 8'h01);
    tick();
    total_cnt++; if (lose_o !== 1'b1) $display("FAIL renest_lose got %b want 1", lose_o); else pass_cnt++;
    total_cnt++; if (state_o !== 2'd2) $display("FAIL renest_state got %0d want 2", state_o); else pass_cnt++;
    total_cnt++; if (mask_o !== 8'h01) $display("FAIL renest_mask got %h want 01", mask_o); else pass_cnt++;
    total_cnt++; if (nest_o !== 1'b0) $display("FAIL renest_nest got %b want 0", nest_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd1) $display("FAIL renest_lives got %0d want 1", lives_o); else pass_cnt++;
    place(0, 8'h01);
    tick();
    total_cnt++; if (state_o !== 2'd0) $display("FAIL renest_respawn got %0d want 0", state_o); else pass_cnt++;
  endtask

  // Hazard hit and fresh nest in the same cycle: death wins. Last life lost.
  task automatic test_priority();
    back = 64'd0;
    back[1*8 +: 8] = 8'h10;
    point = 64'd0;
    point[1*8 +: 8] = 8'h10;
    point[7*8 +: 8] = 8'h02;
    tick();
    total_cnt++; if (state_o !== 2'd2) $display("FAIL prio_state got %0d want 2", state_o); else pass_cnt++;
    total_cnt++; if (lose_o !== 1'b1) $display("FAIL prio_lose got %b want 1", lose_o); else pass_cnt++;
    total_cnt++; if (nest_o !== 1'b0) $display("FAIL prio_nest got %b want 0", nest_o); else pass_cnt++;
    total_cnt++; if (mask_o !== 8'h01) $display("FAIL prio_mask got %h want 01", mask_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd0) $display("FAIL prio_lives got %0d want 0", lives_o); else pass_cnt++;
    total_cnt++; if (gov_o !== 1'b1) $display("FAIL prio_gameover got %b want 1", gov_o); else pass_cnt++;
  endtask

  task automatic test_gameover();
    do_reset();
    back[1*8 +: 8] = 8'h08;
    for (int k = 0; k < 3; k++) begin
      place(1, 8'h08);
      tick();
      total_cnt++; if (lose_o !== 1'b1) $display("FAIL go_lose_%0d got %b want 1", k, lose_o); else pass_cnt++;
      total_cnt++; if (lives_o !== 4'(2 - k)) $display("FAIL go_lives_%0d got %0d want %0d", k, lives_o, 2 - k); else pass_cnt++;
      place(0, 8'h08);
      tick();
    end
    total_cnt++; if (gov_o !== 1'b1) $display("FAIL go_flag got %b want 1", gov_o); else pass_cnt++;
    total_cnt++; if (state_o !== 2'd2) $display("FAIL go_stuck got %0d want 2", state_o); else pass_cnt++;
    tick();
    total_cnt++; if (state_o !== 2'd2) $display("FAIL go_stuck2 got %0d want 2", state_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd0) $display("FAIL go_lives_sat got %0d want 0", lives_o); else pass_cnt++;
    do_reset();
    total_cnt++; if (lives_o !== 4'd3) $display("FAIL go_reset_lives got %0d want 3", lives_o); else pass_cnt++;
    total_cnt++; if (state_o !== 2'd0) $display("FAIL go_reset_state got %0d want 0", state_o); else pass_cnt++;
    total_cnt++; if (gov_o !== 1'b0) $display("FAIL go_reset_flag got %b want 0", gov_o); else pass_cnt++;
  endtask

  task automatic test_powerup();
    do_reset();
    back[1*8 +: 8] = 8'h04;
    back[2*8 +: 8] = 8'h04;
    place(1, 8'h04);
    tick();
    place(2, 8'h04);
    tick();
    total_cnt++; if (pu_o !== 1'b0) $display("FAIL pu_dead got %b want 0", pu_o); else pass_cnt++;
    place(0, 8'h04);
    tick();
    tick();
    place(2, 8'h04);
    tick();
    total_cnt++; if (pu_o !== 1'b1) $display("FAIL pu_pulse got %b want 1", pu_o); else pass_cnt++;
    tick();
    total_cnt++; if (pu_o !== 1'b0) $display("FAIL pu_once got %b want 0", pu_o); else pass_cnt++;
    place(0, 8'h04);
    tick();
    place(2, 8'h04);
    tick();
    total_cnt++; if (pu_o !== 1'b1) $display("FAIL pu_again got %b want 1", pu_o); else pass_cnt++;
  endtask

`ifdef CC_GAME_STATUS_TRACKER_SHIELD_EN
  task automatic test_shield();
    int high = 0;
    do_reset();
    back[1*8 +: 8] = 8'h10;
    back[2*8 +: 8] = 8'h10;
    place(2, 8'h10);
    tick();
    total_cnt++; if (pu_o !== 1'b1) $display("FAIL sh_pu got %b want 1", pu_o); else pass_cnt++;
    if (sh_o === 1'b1) high++;
    place(1, 8'h10);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (sh_o === 1'b1) high++;
      total_cnt++; if (lose_o !== 1'b0) $display("FAIL sh_lose_%0d got %b want 0", c, lose_o); else pass_cnt++;
    end
    total_cnt++; if (high != 4) $display("FAIL sh_cycles got %0d want 4", high); else pass_cnt++;
    tick();
    total_cnt++; if (lose_o !== 1'b1) $display("FAIL sh_after got %b want 1", lose_o); else pass_cnt++;
    // Re-nesting stays fatal under the shield.
    do_reset();
    place(7, 8'h01);
    tick();
    place(0, 8'h01);
    tick();
    back[2*8 +: 8] = 8'h01;
    place(2, 8'h01);
    tick();
    place(7, 8'h01);
    tick();
    total_cnt++; if (sh_o !== 1'b1) $display("FAIL sh_active got %b want 1", sh_o); else pass_cnt++;
    total_cnt++; if (lose_o !== 1'b1) $display("FAIL sh_renest got %b want 1", lose_o); else pass_cnt++;
  endtask
`else
  task automatic test_shield();
    do_reset();
    back[1*8 +: 8] = 8'h10;
    back[2*8 +: 8] = 8'h10;
    place(2, 8'h10);
    tick();
    total_cnt++; if (sh_o !== 1'b0) $display("FAIL sh_off got %b want 0", sh_o); else pass_cnt++;
    place(1, 8'h10);
    tick();
    total_cnt++; if (lose_o !== 1'b1) $display("FAIL sh_off_lose got %b want 1", lose_o); else pass_cnt++;
    total_cnt++; if (sh_o !== 1'b0) $display("FAIL sh_off2 got %b want 0", sh_o); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_override();
    do_reset();
    back[1*8 +: 8] = 8'h20;
    place(1, 8'h20);
    tick();
    place(0, 8'h20);
    tick();
    total_cnt++; if (lives_o !== 4'd2) $display("FAIL ovr_setup got %0d want 2", lives_o); else pass_cnt++;
    place(1, 8'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (lose_o !== 1'b0) $display("FAIL ovr_lose got %b want 0", lose_o); else pass_cnt++;
    total_cnt++; if (lives_o !== 4'd3) $display("FAIL ovr_lives got %0d want 3", lives_o); else pass_cnt++;
    total_cnt++; if (state_o !== 2'd0) $display("FAIL ovr_state got %0d want 0", state_o); else pass_cnt++;
    place(7, 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (nest_o !== 1'b0) $display("FAIL ovr_nest got %b want 0", nest_o); else pass_cnt++;
    total_cnt++; if (mask_o !== 8'h00) $display("FAIL ovr_mask got %h want 00", mask_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_death();
    test_win();
    test_renest();
    test_priority();
    test_gameover();
    test_powerup();
    test_shield();
    test_reset_override();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
